// File: rtl/ram_access_scheduler_pkg.sv
// Shared memory-subsystem definitions: word/address/counter widths used by the
// scheduler and the dual-port RAM it drives.
package ram_access_scheduler_pkg;

  localparam int MEM_DATA_WIDTH = 8;
  localparam int MEM_ADDR_WIDTH = 8;
  localparam int CNT_WIDTH      = 16;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ram_access_scheduler_if.sv
// Two-master request/grant/read-return bus between the masters and the scheduler.
interface ram_access_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);

  logic                  req_a,    req_b;
  logic                  we_a,     we_b;
  logic [ADDR_WIDTH-1:0] addr_a,   addr_b;
  logic [DATA_WIDTH-1:0] wdata_a,  wdata_b;
  logic                  gnt_a,    gnt_b;
  logic                  rvalid_a, rvalid_b;
  logic [DATA_WIDTH-1:0] rdata_a,  rdata_b;

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b
  );

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b
  );

endinterface

// File: rtl/ram_access_scheduler_conflict_arbiter.sv
// Detects same-address accesses involving a write and grants one master,
// alternating the winner on every conflict through the priority flop.
module conflict_arbiter
  import ram_access_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  conflict,
  output logic                  prio_b
);

  prio_e prio_q, prio_nxt;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    prio_nxt = prio_q;
    conflict = req_a & req_b & (addr_a == addr_b) & (we_a | we_b);
    // Grants are forced low during reset so no write can reach the RAM.
    if (!rst) begin
      if (conflict) begin
        gnt_a    = (prio_q == PRIO_A);
        gnt_b    = (prio_q == PRIO_B);
        prio_nxt = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= PRIO_A;
    else     prio_q <= prio_nxt;
  end

  assign prio_b = (prio_q == PRIO_B);

endmodule

// File: rtl/ram_access_scheduler.sv
// Maps masters A/B onto RAM ports A/B, arbitrating same-address conflicts so
// the dual-port RAM never sees a collision; tracks read-valid and conflicts.
module ram_access_scheduler
  import ram_access_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_access_scheduler_if.slave bus,
  output logic                  ram_we_a,
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  output logic [DATA_WIDTH-1:0] ram_din_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_a,
  input  logic [DATA_WIDTH-1:0] ram_dout_b,
  output logic [CNT_WIDTH-1:0]  conflict_cnt,
  output logic                  prio_b
);

  logic gnt_a, gnt_b, conflict;
  logic rvalid_a_q, rvalid_b_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  conflict_arbiter #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_a    (bus.req_a),
    .req_b    (bus.req_b),
    .we_a     (bus.we_a),
    .we_b     (bus.we_b),
    .addr_a   (bus.addr_a),
    .addr_b   (bus.addr_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .conflict (conflict),
    .prio_b   (prio_b)
  );

  // Address and data pass straight through; only the write enable is gated.
  assign ram_we_a   = gnt_a & bus.we_a;
  assign ram_we_b   = gnt_b & bus.we_b;
  assign ram_addr_a = bus.addr_a;
  assign ram_addr_b = bus.addr_b;
  assign ram_din_a  = bus.wdata_a;
  assign ram_din_b  = bus.wdata_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rvalid_a_q <= gnt_a & ~bus.we_a;
      rvalid_b_q <= gnt_b & ~bus.we_b;
      if (conflict) cnt_q <= sat_inc(cnt_q);
    end
  end

  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.rvalid_a = rvalid_a_q;
  assign bus.rvalid_b = rvalid_b_q;
  assign bus.rdata_a  = ram_dout_a;
  assign bus.rdata_b  = ram_dout_b;
  assign conflict_cnt = cnt_q;

endmodule
